// File: rtl/matrix_decompiler.sv
// ============================================================================
// Module      : matrix_decompiler
// Description : Unpacks a framed byte stream (header, row-major matrix,
//               XOR checksum) into addressed element writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_decompiler #(
    parameter int           ROWS        = 32,
    parameter int           COLS        = 32,
    parameter int           ADDR_W      = 5,
    parameter logic [7:0]   HEADER_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [7:0]        axiid,
    output logic              valid_data_out,
    output logic [ADDR_W-1:0] row_addr,
    output logic [ADDR_W-1:0] col_addr,
    output logic [7:0]        matrix_element,
    output logic              matrix_done,
    output logic              frame_error
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PAYLOAD = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [ADDR_W-1:0] c_row_last = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] c_col_last = ADDR_W'(COLS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [7:0]        r_acc;
    // High on the first cycle after reset release: a frame still in flight
    // at that point is the tail of an abandoned frame and is drained silently.
    logic              r_rst_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_row          <= '0;
            r_col          <= '0;
            r_acc          <= '0;
            r_rst_q        <= 1'b1;
            valid_data_out <= 1'b0;
            row_addr       <= '0;
            col_addr       <= '0;
            matrix_element <= '0;
            matrix_done    <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            r_rst_q        <= 1'b0;
            valid_data_out <= 1'b0;
            matrix_done    <= 1'b0;
            frame_error    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (axiiv) begin
                        if (r_rst_q) begin
                            r_state <= S_DRAIN;
                        end else if (axiid == HEADER_BYTE) begin
                            r_state <= S_PAYLOAD;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_acc   <= '0;
                        end else begin
                            frame_error <= 1'b1;
                            r_state     <= S_DRAIN;
                        end
                    end
                end

                S_PAYLOAD: begin
                    if (axiiv) begin
                        valid_data_out <= 1'b1;
                        matrix_element <= axiid;
                        row_addr       <= r_row;
                        col_addr       <= r_col;
                        r_acc          <= r_acc ^ axiid;
                        if (r_col == c_col_last) begin
                            r_col <= '0;
                            if (r_row == c_row_last) begin
                                r_row   <= '0;
                                r_state <= S_CHECK;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else begin
                        frame_error <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                S_CHECK: begin
                    if (axiiv) begin
                        if (axiid == r_acc) begin
                            matrix_done <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        r_state <= S_DRAIN;
                    end else begin
                        frame_error <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (!axiiv) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matrix_decompiler.sv
// ============================================================================
// Module      : tb_matrix_decompiler
// Description : Table-driven, scoreboard-checked bench for matrix_decompiler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_decompiler;

    localparam int ROWS   = 32;
    localparam int COLS   = 32;
    localparam int ADDR_W = 5;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              axiiv = 1'b0;
    logic [7:0]        axiid = 8'h00;
    logic              valid_data_out;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] col_addr;
    logic [7:0]        matrix_element;
    logic              matrix_done;
    logic              frame_error;

    matrix_decompiler #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .ADDR_W      (ADDR_W),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .axiiv          (axiiv),
        .axiid          (axiid),
        .valid_data_out (valid_data_out),
        .row_addr       (row_addr),
        .col_addr       (col_addr),
        .matrix_element (matrix_element),
        .matrix_done    (matrix_done),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] wr_q[$];
    int          done_q[$];
    int          err_q[$];

    typedef struct {
        string      name;
        logic [7:0] hdr;
        int         npay;
        bit         has_trailer;
        logic [7:0] trailer;
        int         nextra;
        int         exp_writes;
        bit         exp_done;
        bit         exp_err;
        int         pulse_idx;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] extra[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] pat(input int i);
        return (i % 2 == 1) ? 8'hFF : 8'hAA;
    endfunction

    function automatic vec_t mk(input string name, input logic [7:0] hdr, input int npay,
                                input bit has_tr, input logic [7:0] tr, input int nextra,
                                input int wr, input bit dn, input bit er, input int pidx);
        vec_t v;
        v.name = name; v.hdr = hdr; v.npay = npay; v.has_trailer = has_tr;
        v.trailer = tr; v.nextra = nextra; v.exp_writes = wr;
        v.exp_done = dn; v.exp_err = er; v.pulse_idx = pidx;
        return v;
    endfunction

    // Inputs change just after the falling edge, so the monitor below has
    // already sampled the response to the previous byte.
    task automatic step(input logic v, input logic [7:0] d);
        axiiv = v;
        axiid = d;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push_write(input int idx, input logic [7:0] d);
        wr_q.push_back({14'd0, ADDR_W'(idx / COLS), ADDR_W'(idx % COLS), d});
    endtask

    task automatic check_drained(input string name);
        chk({name, "_writes_pending"}, wr_q.size(), 0);
        chk({name, "_done_pending"}, done_q.size(), 0);
        chk({name, "_err_pending"}, err_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t t);
        int L;
        L = 1 + t.npay + (t.has_trailer ? 1 : 0) + t.nextra;
        for (int k = 0; k <= L; k++) begin
            logic [7:0] d;
            if (k == 0)                                d = t.hdr;
            else if (k <= t.npay)                      d = pat(k - 1);
            else if (t.has_trailer && k == t.npay + 1) d = t.trailer;
            else if (k < L)                            d = extra[(k - t.npay - 1 - (t.has_trailer ? 1 : 0)) % 4];
            else                                       d = 8'h00;
            if (k >= 1 && (k - 1) < t.exp_writes) push_write(k - 1, d);
            if (k == t.pulse_idx) begin
                if (t.exp_done) done_q.push_back(cyc + 1);
                if (t.exp_err)  err_q.push_back(cyc + 1);
            end
            step(k < L, d);
        end
        check_drained(t.name);
    endtask

    always @(negedge clk) begin
        if (valid_data_out) begin
            logic [31:0] exp;
            exp = (wr_q.size() > 0) ? wr_q.pop_front() : 32'hFFFF_FFFF;
            chk("write", {14'd0, row_addr, col_addr, matrix_element}, exp);
        end
        if (matrix_done) begin
            int exp;
            exp = (done_q.size() > 0) ? done_q.pop_front() : -1;
            chk("done_cycle", cyc, exp);
        end
        if (frame_error) begin
            int exp;
            exp = (err_q.size() > 0) ? err_q.pop_front() : -1;
            chk("err_cycle", cyc, exp);
        end
        if (matrix_done || frame_error)
            chk("done_err_exclusive", {31'd0, matrix_done & frame_error}, 32'd0);
    end

    initial begin
        extra[0] = 8'hDE; extra[1] = 8'hAD; extra[2] = 8'hBE; extra[3] = 8'hEF;
        //            name        hdr    npay  tr trail  ext wr    dn er pulse
        vecs[0] = mk("good",      8'hA5, 1024, 1, 8'h00, 0, 1024, 1, 0, 1025);
        vecs[1] = mk("bad_ck",    8'hA5, 1024, 1, 8'h01, 0, 1024, 0, 1, 1025);
        vecs[2] = mk("bad_hdr",   8'h5A, 1026, 0, 8'h00, 0, 0,    0, 1, 0);
        vecs[3] = mk("truncated", 8'hA5, 100,  0, 8'h00, 0, 100,  0, 1, 101);
        vecs[4] = mk("good_b2b",  8'hA5, 1024, 1, 8'h00, 0, 1024, 1, 0, 1025);
        vecs[5] = mk("trailing",  8'hA5, 1024, 1, 8'h00, 4, 1024, 1, 0, 1025);

        rst = 1'b0;
        repeat (3) step(1'b0, 8'h00);
        chk("rst_valid", {31'd0, valid_data_out}, 32'd0);
        chk("rst_row",   {27'd0, row_addr}, 32'd0);
        chk("rst_col",   {27'd0, col_addr}, 32'd0);
        chk("rst_elem",  {24'd0, matrix_element}, 32'd0);
        chk("rst_done",  {31'd0, matrix_done}, 32'd0);
        chk("rst_err",   {31'd0, frame_error}, 32'd0);
        rst = 1'b1;
        step(1'b0, 8'h00);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset for one cycle in the middle of the payload, axiiv held high.
        step(1'b1, 8'hA5);
        for (int i = 0; i < 500; i++) begin
            push_write(i, pat(i));
            step(1'b1, pat(i));
        end
        rst = 1'b0;
        step(1'b1, pat(500));
        rst = 1'b1;
        chk("midrst_valid", {31'd0, valid_data_out}, 32'd0);
        chk("midrst_row",   {27'd0, row_addr}, 32'd0);
        chk("midrst_col",   {27'd0, col_addr}, 32'd0);
        chk("midrst_elem",  {24'd0, matrix_element}, 32'd0);
        chk("midrst_done",  {31'd0, matrix_done}, 32'd0);
        chk("midrst_err",   {31'd0, frame_error}, 32'd0);
        for (int i = 501; i < 1024; i++) step(1'b1, pat(i));
        step(1'b1, 8'h00);
        step(1'b0, 8'h00);
        check_drained("midrst_tail");
        run_vec(vecs[0]);

        repeat (2) step(1'b0, 8'h00);
        check_drained("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
